dmem_port_scheduler: RTL and testbench

- Owns the single-port data RAM and decides which requester drives it each cycle.
- Two modes:
  - PROG: the UART programmer (UPG) loads memory.
  - RUN: the CPU load/store port and an auxiliary port (display/DMA reader) share the RAM under round-robin arbitration.
- Registers the RAM command, returns read data with a fixed latency, and drains in-flight reads before a mode switch.
- Sits between the CPU/aux datapath, the UART programmer and the RAM macro, which is clocked on this block's clk.

---
 rtl/dmem_port_scheduler.sv | 159 +++++++++++++++
 tb/tb_dmem_port_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_scheduler.sv
// Data RAM port scheduler: UART programmer owns the RAM in PROG, CPU and aux share it round-robin in RUN.
// Read data returns two cycles after grant; in-flight reads are drained before handing the RAM back to the programmer.
module dmem_port_scheduler #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n_i,
  input  logic              upg_rst_i,
  input  logic              upg_done_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_addr_i,
  input  logic [DATA_W-1:0] upg_data_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  input  logic              aux_req_i,
  input  logic              aux_we_i,
  input  logic [ADDR_W-1:0] aux_addr_i,
  input  logic [DATA_W-1:0] aux_wdata_i,
  output logic              aux_gnt_o,
  output logic              aux_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              mode_run_o
);

  typedef enum logic [1:0] {PROG, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic                kick;
  logic                rr_last_aux;
  logic                t1_vld, t1_aux;
  logic                pipe_empty;
  logic                buf_vld;
  logic [ADDR_W-1:0]   buf_addr;
  logic [DATA_W-1:0]   buf_data;
  logic                upg_issue_ok;
  logic                cmd_vld, cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                buf_set, buf_clr;

  assign kick       = upg_rst_i | upg_done_i;
  assign pipe_empty = !t1_vld && !cpu_rvalid_o && !aux_rvalid_o;

  always_comb begin
    state_nxt = state;
    cpu_gnt_o = 1'b0;
    aux_gnt_o = 1'b0;
    case (state)
      PROG: begin
        if (kick) state_nxt = RUN;
      end
      RUN: begin
        if (!kick) begin
          state_nxt = DRAIN;
        end else if (cpu_req_i && aux_req_i) begin
          // Conflict: whoever was not granted last goes first.
          cpu_gnt_o = rr_last_aux;
          aux_gnt_o = !rr_last_aux;
        end else begin
          cpu_gnt_o = cpu_req_i;
          aux_gnt_o = aux_req_i;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_nxt = PROG;
      end
      default: state_nxt = PROG;
    endcase
  end

  // The edge leaving DRAIN already counts as PROG so a buffered write lands in the first PROG cycle.
  assign upg_issue_ok = (state == PROG) || (state == DRAIN && state_nxt == PROG);

  always_comb begin
    cmd_vld   = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = ram_addr_o;
    cmd_wdata = ram_wdata_o;
    buf_set   = 1'b0;
    buf_clr   = 1'b0;
    if (cpu_gnt_o) begin
      cmd_vld   = 1'b1;
      cmd_we    = cpu_we_i;
      cmd_addr  = cpu_addr_i;
      cmd_wdata = cpu_wdata_i;
    end else if (aux_gnt_o) begin
      cmd_vld   = 1'b1;
      cmd_we    = aux_we_i;
      cmd_addr  = aux_addr_i;
      cmd_wdata = aux_wdata_i;
    end else if (upg_issue_ok) begin
      if (buf_vld) begin
        cmd_vld   = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = buf_addr;
        cmd_wdata = buf_data;
        buf_set   = upg_wen_i;
        buf_clr   = !upg_wen_i;
      end else if (upg_wen_i) begin
        cmd_vld   = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = upg_addr_i;
        cmd_wdata = upg_data_i;
      end
    end else if (state == DRAIN && upg_wen_i) begin
      buf_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state        <= PROG;
      mode_run_o   <= 1'b0;
      rr_last_aux  <= 1'b1;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_wdata_o  <= '0;
      t1_vld       <= 1'b0;
      t1_aux       <= 1'b0;
      cpu_rvalid_o <= 1'b0;
      aux_rvalid_o <= 1'b0;
      rdata_o      <= '0;
      buf_vld      <= 1'b0;
      buf_addr     <= '0;
      buf_data     <= '0;
    end else begin
      state      <= state_nxt;
      mode_run_o <= (state_nxt == RUN);
      ram_we_o   <= cmd_vld & cmd_we;
      if (cmd_vld) begin
        ram_addr_o  <= cmd_addr;
        ram_wdata_o <= cmd_wdata;
      end
      if (cpu_gnt_o || aux_gnt_o) rr_last_aux <= aux_gnt_o;
      t1_vld       <= (cpu_gnt_o && !cpu_we_i) || (aux_gnt_o && !aux_we_i);
      t1_aux       <= aux_gnt_o;
      cpu_rvalid_o <= t1_vld && !t1_aux;
      aux_rvalid_o <= t1_vld && t1_aux;
      if (t1_vld) rdata_o <= ram_rdata_i;
      if (buf_set) begin
        buf_vld  <= 1'b1;
        buf_addr <= upg_addr_i;
        buf_data <= upg_data_i;
      end else if (buf_clr) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_scheduler.sv
// Directed bench for dmem_port_scheduler: per-cycle vector table plus a hand-written DRAIN/re-kick sequence.
module tb_dmem_port_scheduler;

  localparam int AW = 14;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, upg_rst, upg_done, upg_wen;
  logic [AW-1:0] upg_addr;
  logic [DW-1:0] upg_data;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          aux_req, aux_we, aux_gnt, aux_rvalid;
  logic [AW-1:0] aux_addr;
  logic [DW-1:0] aux_wdata;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic          ram_we, mode_run;
  logic [AW-1:0] ram_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  dmem_port_scheduler #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n_i(rst_n), .upg_rst_i(upg_rst), .upg_done_i(upg_done),
    .upg_wen_i(upg_wen), .upg_addr_i(upg_addr), .upg_data_i(upg_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .aux_req_i(aux_req), .aux_we_i(aux_we), .aux_addr_i(aux_addr), .aux_wdata_i(aux_wdata),
    .aux_gnt_o(aux_gnt), .aux_rvalid_o(aux_rvalid), .rdata_o(rdata),
    .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .mode_run_o(mode_run)
  );

  // RAM model: write at the edge, read data follows the registered address within the cycle.
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  typedef struct {
    logic          rst_n, done, wen;
    logic [AW-1:0] ua;
    logic [DW-1:0] ud;
    logic          cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          ar;
    logic [AW-1:0] aa;
    logic          e_cg, e_ag, e_crv, e_arv;
    logic [DW-1:0] e_rd;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_run, e_all;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic done, input logic wen, input logic [AW-1:0] ua, input logic [DW-1:0] ud,
    input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
    input logic ar, input logic [AW-1:0] aa,
    input logic cg, input logic ag, input logic crv, input logic arv, input logic [DW-1:0] rd,
    input logic we, input logic [AW-1:0] ea, input logic [DW-1:0] ed, input logic run);
    vec_t v;
    v.rst_n = 1'b1; v.done = done; v.wen = wen; v.ua = ua; v.ud = ud;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.ar = ar; v.aa = aa;
    v.e_cg = cg; v.e_ag = ag; v.e_crv = crv; v.e_arv = arv; v.e_rd = rd;
    v.e_we = we; v.e_addr = ea; v.e_wd = ed; v.e_run = run; v.e_all = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst_n; upg_rst = 1'b0; upg_done = v.done;
    upg_wen = v.wen; upg_addr = v.ua; upg_data = v.ud;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    aux_req = v.ar; aux_we = 1'b0; aux_addr = v.aa; aux_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rst_n = 1'b0; upg_rst = 1'b0; upg_done = 1'b0; upg_wen = 1'b0;
    upg_addr = '0; upg_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 1'b0; aux_we = 1'b0; aux_addr = '0; aux_wdata = '0;

    //       done wen ua        ud            cr cw ca       cd            ar aa       | cg ag crv arv rdata        we addr     wdata         run
    vecs.push_back(mk(0, 1, 14'h0010, 32'hDEADBEEF, 1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 0
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            1, 14'h0010, 32'hDEADBEEF, 0)); // 1
    vecs.push_back(mk(0, 1, 14'h0011, 32'h1,        1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 2
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            1, 14'h0011, 32'h1,        0)); // 3
    vecs.push_back(mk(0, 1, 14'h3FFF, 32'hA5A5A5A5, 1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 4
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            1, 14'h3FFF, 32'hA5A5A5A5, 0)); // 5
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 6
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           1, 0, 0, 0, 0,            0, 0,        0,            1)); // 7
    vecs.push_back(mk(1, 0, 0, 0,                   0, 0, 0, 0,        0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            1)); // 8
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    0, 1, 1, 0, 32'hDEADBEEF, 0, 0,        0,            1)); // 9
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    1, 0, 0, 0, 0,            0, 0,        0,            1)); // 10
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    0, 1, 0, 1, 32'h1,        0, 0,        0,            1)); // 11
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    1, 0, 1, 0, 32'hA5A5A5A5, 0, 0,        0,            1)); // 12
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    0, 1, 0, 1, 32'h1,        0, 0,        0,            1)); // 13
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h3FFF, 0, 1, 14'h0011,    1, 0, 1, 0, 32'hA5A5A5A5, 0, 0,        0,            1)); // 14
    vecs.push_back(mk(1, 0, 0, 0,                   1, 1, 14'h0020, 32'h12345678, 0, 0, 1, 0, 0, 1, 32'h1,       0, 0,        0,            1)); // 15
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0020, 0, 0, 0,           1, 0, 1, 0, 32'hA5A5A5A5, 1, 14'h0020, 32'h12345678, 1)); // 16
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0020, 0, 0, 0,           1, 0, 0, 0, 0,            0, 0,        0,            1)); // 17
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 1, 0, 32'h12345678, 0, 0,        0,            1)); // 18
    vecs.push_back(mk(0, 1, 14'h0030, 32'hCAFEF00D, 1, 0, 14'h0010, 0, 0, 0,           0, 0, 1, 0, 32'h12345678, 0, 0,        0,            0)); // 19
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 20
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            1, 14'h0030, 32'hCAFEF00D, 0)); // 21
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0030, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 22
    vecs.push_back(mk(1, 0, 0, 0,                   1, 0, 14'h0030, 0, 0, 0,           1, 0, 0, 0, 0,            0, 0,        0,            1)); // 23
    vecs.push_back(mk(1, 0, 0, 0,                   0, 0, 0, 0,        0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            1)); // 24
    vecs[24].rst_n = 1'b0;
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 25
    vecs[25].e_all = 1'b1;
    vecs.push_back(mk(0, 0, 0, 0,                   1, 0, 14'h0010, 0, 0, 0,           0, 0, 0, 0, 0,            0, 0,        0,            0)); // 26
    vecs[26].e_all = 1'b1;

    next_cycle();
    next_cycle();
    chk("reset cpu_gnt", cpu_gnt, 0);
    chk("reset aux_gnt", aux_gnt, 0);
    chk("reset rvalids", {cpu_rvalid, aux_rvalid}, 0);
    chk("reset rdata", rdata, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset ram_addr", ram_addr, 0);
    chk("reset ram_wdata", ram_wdata, 0);
    chk("reset mode_run", mode_run, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d cpu_gnt", i), cpu_gnt, vecs[i].e_cg);
      chk($sformatf("v%0d aux_gnt", i), aux_gnt, vecs[i].e_ag);
      chk($sformatf("v%0d cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
      chk($sformatf("v%0d aux_rvalid", i), aux_rvalid, vecs[i].e_arv);
      chk($sformatf("v%0d ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d mode_run", i), mode_run, vecs[i].e_run);
      if (vecs[i].e_crv || vecs[i].e_arv || vecs[i].e_all)
        chk($sformatf("v%0d rdata", i), rdata, vecs[i].e_rd);
      if (vecs[i].e_we || vecs[i].e_all) begin
        chk($sformatf("v%0d ram_addr", i), ram_addr, vecs[i].e_addr);
        chk($sformatf("v%0d ram_wdata", i), ram_wdata, vecs[i].e_wd);
      end
      next_cycle();
    end

    // Kick drops for one cycle with a read in flight, then returns mid-DRAIN:
    // DRAIN finishes, PROG lasts one cycle, RUN resumes.
    upg_done = 1'b1; cpu_req = 1'b0;
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0010; #1;
    chk("h1 mode_run", mode_run, 1);
    chk("h1 cpu_gnt", cpu_gnt, 1);
    next_cycle();
    upg_done = 1'b0; cpu_req = 1'b0; #1;
    chk("h2 cpu_gnt", cpu_gnt, 0);
    chk("h2 mode_run", mode_run, 1);
    next_cycle();
    upg_done = 1'b1; #1;
    chk("h3 mode_run", mode_run, 0);
    chk("h3 cpu_rvalid", cpu_rvalid, 1);
    chk("h3 rdata", rdata, 32'hDEADBEEF);
    next_cycle();
    cpu_req = 1'b1; #1;
    chk("h4 mode_run", mode_run, 0);
    chk("h4 cpu_rvalid", cpu_rvalid, 0);
    chk("h4 cpu_gnt", cpu_gnt, 0);
    next_cycle();
    chk("h5 mode_run", mode_run, 0);
    chk("h5 cpu_gnt", cpu_gnt, 0);
    next_cycle();
    chk("h6 mode_run", mode_run, 1);
    chk("h6 cpu_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
